// File: rtl/vga_text_overlay_gen.sv
// VGA timing generator with a hex-digit text overlay; sync, de and RGB leave
// through the same two registered pixel stages so they stay mutually aligned.
module vga_text_overlay_gen #(
   parameter int unsigned PIX_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned TEXT_X   = 16,
   parameter int unsigned TEXT_Y   = 16,
   parameter int unsigned SCALE    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] value,
   input  logic [23:0] fg_rgb,
   input  logic [23:0] bg_rgb,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        h_sync,
   output logic        v_sync,
   output logic        de,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW       = $clog2(H_TOTAL);
   localparam int unsigned VW       = $clog2(V_TOTAL);
   localparam int unsigned DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int unsigned SW       = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int unsigned BOX_W    = 6 * DIGITS * SCALE;
   localparam int unsigned BOX_H    = 8 * SCALE;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [DW-1:0] div_cnt, div_next;
   logic          pix_ce, next_ce, h_wrap;
   logic [HW-1:0] h_cnt, h_next;
   logic [VW-1:0] v_cnt, v_next;
   logic [31:0]   hx, vy, hx_next, vy_next;
   logic          act0, hs0, vs0, box0;

   logic [SW-1:0] x_sub, y_sub;
   logic [2:0]    x_col, x_dig, y_row;

   logic          s1_act, s1_hs, s1_vs, s1_box;
   logic [2:0]    s1_dig, s1_col, s1_row;
   logic [31:0]   val_q;
   logic [3:0]    nib;
   logic [7:0]    glyph;
   logic          pix_on;

   function automatic logic [5:0] font_row(input logic [3:0] n, input logic [2:0] row);
      logic [19:0] g;
      logic [3:0]  mid;
      case (n)
         4'h0: g = 20'hF999F;  4'h1: g = 20'h26227;
         4'h2: g = 20'hF1F8F;  4'h3: g = 20'hF171F;
         4'h4: g = 20'h99F11;  4'h5: g = 20'hF8F1F;
         4'h6: g = 20'hF8F9F;  4'h7: g = 20'hF1244;
         4'h8: g = 20'hF9F9F;  4'h9: g = 20'hF9F1F;
         4'hA: g = 20'h69F99;  4'hB: g = 20'hE9E9E;
         4'hC: g = 20'h78887;  4'hD: g = 20'hE999E;
         4'hE: g = 20'hF8E8F;  default: g = 20'hF8E88;
      endcase
      // Only rows 1..5 and the middle four columns carry ink.
      case (row)
         3'd1:    mid = g[19:16];
         3'd2:    mid = g[15:12];
         3'd3:    mid = g[11:8];
         3'd4:    mid = g[7:4];
         3'd5:    mid = g[3:0];
         default: mid = '0;
      endcase
      return {1'b0, mid, 1'b0};
   endfunction

   always_comb begin
      pix_ce   = (div_cnt == DW'(PIX_DIV - 1));
      div_next = pix_ce ? '0 : div_cnt + 1'b1;
      next_ce  = (div_next == DW'(PIX_DIV - 1));
      h_wrap   = (h_cnt == HW'(H_TOTAL - 1));
      h_next   = h_cnt;
      v_next   = v_cnt;
      if (pix_ce) begin
         h_next = h_wrap ? '0 : h_cnt + 1'b1;
         if (h_wrap)
            v_next = (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end
      hx      = 32'(h_cnt);
      vy      = 32'(v_cnt);
      hx_next = 32'(h_next);
      vy_next = 32'(v_next);
      act0    = (hx < H_ACTIVE) && (vy < V_ACTIVE);
      hs0     = (hx >= HS_START && hx < HS_END) ? HS_POL : ~HS_POL;
      vs0     = (vy >= VS_START && vy < VS_END) ? VS_POL : ~VS_POL;
      box0    = (hx >= TEXT_X) && (hx < TEXT_X + BOX_W) &&
                (vy >= TEXT_Y) && (vy < TEXT_Y + BOX_H);
   end

   always_comb begin
      nib = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (32'(s1_dig) == i) nib = val_q[4*(DIGITS-1-i) +: 4];
      glyph  = {2'b00, font_row(nib, s1_row)};
      pix_on = s1_box && glyph[3'd5 - s1_col];
   end

   // Glyph position is tracked by scale sub-counters that restart when the
   // raster enters the text box, so no division is needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt     <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
         val_q       <= '0;
         x_sub       <= '0;
         x_col       <= '0;
         x_dig       <= '0;
         y_sub       <= '0;
         y_row       <= '0;
         s1_act      <= 1'b0;
         s1_hs       <= ~HS_POL;
         s1_vs       <= ~VS_POL;
         s1_box      <= 1'b0;
         s1_dig      <= '0;
         s1_col      <= '0;
         s1_row      <= '0;
         de          <= 1'b0;
         h_sync      <= ~HS_POL;
         v_sync      <= ~VS_POL;
         {red, green, blue} <= '0;
      end else begin
         div_cnt     <= div_next;
         h_cnt       <= h_next;
         v_cnt       <= v_next;
         frame_start <= next_ce && (h_next == '0) && (v_next == '0);
         if (pix_ce) begin
            if (h_cnt == '0 && v_cnt == '0)
               val_q <= value;
            if (hx_next == TEXT_X) begin
               x_sub <= '0;
               x_col <= '0;
               x_dig <= '0;
            end else if (hx >= TEXT_X) begin
               if (x_sub == SW'(SCALE - 1)) begin
                  x_sub <= '0;
                  if (x_col == 3'd5) begin
                     x_col <= '0;
                     x_dig <= x_dig + 1'b1;
                  end else begin
                     x_col <= x_col + 1'b1;
                  end
               end else begin
                  x_sub <= x_sub + 1'b1;
               end
            end
            if (h_wrap) begin
               if (vy_next == TEXT_Y) begin
                  y_sub <= '0;
                  y_row <= '0;
               end else if (vy >= TEXT_Y) begin
                  if (y_sub == SW'(SCALE - 1)) begin
                     y_sub <= '0;
                     y_row <= y_row + 1'b1;
                  end else begin
                     y_sub <= y_sub + 1'b1;
                  end
               end
            end
            s1_act <= act0;
            s1_hs  <= hs0;
            s1_vs  <= vs0;
            s1_box <= box0;
            s1_dig <= x_dig;
            s1_col <= x_col;
            s1_row <= y_row;
            de     <= s1_act;
            h_sync <= s1_hs;
            v_sync <= s1_vs;
            {red, green, blue} <= s1_act ? (pix_on ? fg_rgb : bg_rgb) : '0;
         end
      end
   end

endmodule
